// File: rtl/prefetch_queue.sv
// Prefetch queue between the instruction memory response path and fetch/decode: FWFT read side,
// epoch-tagged flush discard. Optional same-cycle empty-queue bypass when PFQ_BYPASS_EN is defined.
module prefetch_queue #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned EPOCH_W      = 2,
  parameter int unsigned AFULL_THRESH = 6,
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [DATA_W-1:0]  wr_data_i,
  input  logic [PC_W-1:0]    wr_pc_i,
  input  logic [EPOCH_W-1:0] wr_epoch_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic [PC_W-1:0]    rd_pc_o,
  input  logic               flush_i,
  output logic [EPOCH_W-1:0] cur_epoch_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               almost_full_o,
  output logic               drop_pulse_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W+DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wptr_q, rptr_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [EPOCH_W-1:0]     epoch_q;
  logic                   drop_q, drop_d;
  logic                   epoch_ok, pop, push, byp;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == CNT_W'(DEPTH));
  assign almost_full_o = (count_q >= CNT_W'(AFULL_THRESH));
  assign count_o       = count_q;
  assign cur_epoch_o   = epoch_q;
  assign drop_pulse_o  = drop_q;

  assign epoch_ok   = (wr_epoch_i == epoch_q);
  assign pop        = !empty_o && rd_ready_i && !flush_i;
  assign wr_ready_o = !full_o || (!empty_o && rd_ready_i);

`ifdef PFQ_BYPASS_EN
  // Empty queue with a waiting consumer: hand the word straight through, never stored.
  assign byp = empty_o && wr_valid_i && epoch_ok && rd_ready_i && !flush_i;
`else
  assign byp = 1'b0;
`endif

  assign push   = wr_valid_i && wr_ready_o && epoch_ok && !flush_i && !byp;
  // The flush cycle's old-epoch write is an expected casualty, not a stale response.
  assign drop_d = wr_valid_i && !epoch_ok && !flush_i;
  assign rd_valid_o = !empty_o || byp;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rd_data_o = '0;
    rd_pc_o   = '0;
    if (byp) begin
      rd_data_o = wr_data_i;
      rd_pc_o   = wr_pc_i;
    end else if (!empty_o) begin
      {rd_pc_o, rd_data_o} = mem_q[rptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      epoch_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (flush_i) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
        epoch_q <= epoch_q + EPOCH_W'(1);
      end else begin
        if (push) wptr_q <= wptr_q + PTR_W'(1);
        if (pop)  rptr_q <= rptr_q + PTR_W'(1);
        count_q <= count_d;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {wr_pc_i, wr_data_i};
  end

endmodule
